id_ex_shift_stage: RTL and testbench
====================================

Name: id_ex_shift_stage

Overview:
- ID/EX pipeline register for the shift datapath. Decodes the ID-stage instruction into shifter controls (srl, sra, ls) and the 4-bit shamt.
- Resolves the src0 operand through EX/MEM forwarding and detects load-use hazards.
- Stalls the front end on a hazard and registers everything that feeds the combinational shifter in EX.

Parameters:
- OP_SLL, 4'b0100, opcode for shift left logical
- OP_SRL, 4'b0101, opcode for shift right logical
- OP_SRA, 4'b0110, opcode for shift right arithmetic
- OP_LW, 4'b1000, opcode for load word (hazard source only)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] shamt/imm
- id_rs_data  in  16  register-file read of rs; write-before-read already applied for WB
- flush  in  1  squash the instruction entering EX (branch redirect)
- ex_result  in  16  shifter opt of the instruction currently in EX
- mem_wr_en  in  1  MEM-stage instruction writes a register
- mem_rd  in  4  MEM-stage destination
- mem_result  in  16  MEM-stage writeback value (load data for LW)
- id_stall  out  1  hold PC/IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_src0  out  16  shifter src0
- ex_shamt  out  4  shifter shamt
- ex_srl, ex_sra, ex_ls  out  1 each  shifter controls; at most one high
- ex_rd  out  4  destination register
- ex_wr_en  out  1  EX instruction writes rd
- ex_is_load  out  1  EX instruction is LW

Behaviour:
- Reset: all outputs and registers go to 0 asynchronously. A bubble in EX drives zero controls, so the shifter passes src0 unchanged.

Decode (combinational, from id_instr):
- SLL: ls=1. SRL: srl=1. SRA: sra=1.
- All three shift opcodes: wr_en=1, shamt=instr[3:0].
- LW: is_load=1, wr_en=1, controls=0, shamt=0.
- Any other opcode: valid passes through, controls=0, wr_en=0, is_load=0.
- Controls are never more than one-hot.
- A rd of 0 forces wr_en=0, because r0 is hardwired to zero.

rs_used:
- Set for the shift opcodes and LW.
- Clear for other opcodes.

Forwarding for src0 (combinational, priority order):
1. rs==0: src0 is 0.
2. ex_valid & ex_wr_en & !ex_is_load & ex_rd==rs: src0 = ex_result.
3. mem_wr_en & mem_rd==rs: src0 = mem_result.
4. Otherwise: src0 = id_rs_data.

Load-use hazard:
- Condition: id_valid & rs_used & rs!=0 & ex_valid & ex_is_load & ex_rd==rs.
- Effect: id_stall=1 for exactly one cycle. The EX register captures a bubble (valid, wr_en, is_load, controls, rd all 0; src0 and shamt 0).
- Next cycle the load is in MEM, and its data is forwarded via priority 3.

Register update, every rising edge, with this priority:
1. flush: capture a bubble. id_stall is still driven by the hazard logic, but flush wins for EX contents.
2. Hazard: capture a bubble.
3. !id_valid: capture a bubble.
4. Otherwise: capture the decoded fields and the forwarded src0.

Other rules:
- Latency: one cycle from ID to EX outputs. Throughput is one instruction per cycle with no hazards.
- Back-to-back dependent shifts forward with no stall via ex_result.
- shamt=0 is legal: the control is still asserted and the shifter returns src0.
- Reset mid-stall clears EX immediately. id_stall deasserts because ex_valid becomes 0.

Test Plan:
- Reset: assert rst mid-cycle with EX full -> all outputs 0 immediately, without waiting for a clock edge. id_stall=0.
- Decode: SRA r3,r2,#5 with id_rs_data=16'h8000, no forwarding -> next cycle ex_sra=1, ex_srl=0, ex_ls=0, ex_shamt=5, ex_src0=8000, ex_rd=3, ex_wr_en=1.
- EX forward: SLL r4,r1,#1 then SRL r5,r4,#2 back-to-back, with ex_result=16'h0246 while SLL is in EX -> SRL captures ex_src0=0246, no stall.
- Priority: ex_rd=mem_rd=rs=7, ex_result=1111, mem_result=2222 -> src0=1111. Rerun with ex_wr_en=0 -> src0=2222.
- Load-use: LW r6 then SLL r2,r6,#4 -> id_stall=1 one cycle, EX bubble (ex_valid=0). Next cycle mem_result=00F0 is forwarded, giving ex_src0=00F0, ex_ls=1, id_stall=0.
- Flush plus r0: flush asserted with a valid shift in ID -> EX bubble. Separately, SRL r0,r0,#3 -> ex_src0=0, ex_wr_en=0, ex_srl=1.

Source files
------------

// File: rtl/id_ex_shift_if.sv
// ID/EX shift-stage bus: ID operands, EX/MEM forwarding taps, and the registered EX controls.
// master drives the ID/MEM side; slave is the pipeline register itself.
interface id_ex_shift_if;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_rs_data;
    logic        flush;
    logic [15:0] ex_result;
    logic        mem_wr_en;
    logic [3:0]  mem_rd;
    logic [15:0] mem_result;

    logic        id_stall;
    logic        ex_valid;
    logic [15:0] ex_src0;
    logic [3:0]  ex_shamt;
    logic        ex_srl;
    logic        ex_sra;
    logic        ex_ls;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic        ex_is_load;

    modport master (
        output id_valid, id_instr, id_rs_data, flush, ex_result,
               mem_wr_en, mem_rd, mem_result,
        input  id_stall, ex_valid, ex_src0, ex_shamt, ex_srl, ex_sra,
               ex_ls, ex_rd, ex_wr_en, ex_is_load
    );

    modport slave (
        input  id_valid, id_instr, id_rs_data, flush, ex_result,
               mem_wr_en, mem_rd, mem_result,
        output id_stall, ex_valid, ex_src0, ex_shamt, ex_srl, ex_sra,
               ex_ls, ex_rd, ex_wr_en, ex_is_load
    );
endinterface

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register for the shift datapath: decode, src0 forwarding,
// load-use stall, and registered controls for the combinational EX shifter.
module id_ex_shift_stage #(
    parameter logic [3:0] OP_SLL = 4'b0100,
    parameter logic [3:0] OP_SRL = 4'b0101,
    parameter logic [3:0] OP_SRA = 4'b0110,
    parameter logic [3:0] OP_LW  = 4'b1000
) (
    input  logic           clk,
    input  logic           rst,
    id_ex_shift_if.slave   bus
);

    logic [3:0]  w_opcode;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs;
    logic [3:0]  w_imm;

    logic        w_dec_srl;
    logic        w_dec_sra;
    logic        w_dec_ls;
    logic        w_dec_wr_en;
    logic        w_dec_is_load;
    logic        w_dec_rs_used;
    logic [3:0]  w_dec_shamt;

    logic [15:0] w_src0;
    logic        w_hazard;
    logic        w_bubble;

    logic        r_ex_valid;
    logic [15:0] r_ex_src0;
    logic [3:0]  r_ex_shamt;
    logic        r_ex_srl;
    logic        r_ex_sra;
    logic        r_ex_ls;
    logic [3:0]  r_ex_rd;
    logic        r_ex_wr_en;
    logic        r_ex_is_load;

    assign w_opcode = bus.id_instr[15:12];
    assign w_rd     = bus.id_instr[11:8];
    assign w_rs     = bus.id_instr[7:4];
    assign w_imm    = bus.id_instr[3:0];

    always_comb begin
        w_dec_srl     = 1'b0;
        w_dec_sra     = 1'b0;
        w_dec_ls      = 1'b0;
        w_dec_wr_en   = 1'b0;
        w_dec_is_load = 1'b0;
        w_dec_rs_used = 1'b0;
        w_dec_shamt   = 4'd0;
        case (w_opcode)
            OP_SLL: begin
                w_dec_ls      = 1'b1;
                w_dec_wr_en   = 1'b1;
                w_dec_rs_used = 1'b1;
                w_dec_shamt   = w_imm;
            end
            OP_SRL: begin
                w_dec_srl     = 1'b1;
                w_dec_wr_en   = 1'b1;
                w_dec_rs_used = 1'b1;
                w_dec_shamt   = w_imm;
            end
            OP_SRA: begin
                w_dec_sra     = 1'b1;
                w_dec_wr_en   = 1'b1;
                w_dec_rs_used = 1'b1;
                w_dec_shamt   = w_imm;
            end
            OP_LW: begin
                w_dec_is_load = 1'b1;
                w_dec_wr_en   = 1'b1;
                w_dec_rs_used = 1'b1;
            end
            default: ;
        endcase
        // r0 is hardwired to zero, so nothing ever writes it
        if (w_rd == 4'd0)
            w_dec_wr_en = 1'b0;
    end

    // Load data is not ready while the load sits in EX, so ex_result is skipped for loads.
    always_comb begin
        if (w_rs == 4'd0)
            w_src0 = 16'd0;
        else if (r_ex_valid && r_ex_wr_en && !r_ex_is_load && (r_ex_rd == w_rs))
            w_src0 = bus.ex_result;
        else if (bus.mem_wr_en && (bus.mem_rd == w_rs))
            w_src0 = bus.mem_result;
        else
            w_src0 = bus.id_rs_data;
    end

    assign w_hazard = bus.id_valid && w_dec_rs_used && (w_rs != 4'd0) &&
                      r_ex_valid && r_ex_is_load && (r_ex_rd == w_rs);

    assign w_bubble = bus.flush || w_hazard || !bus.id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_src0    <= 16'd0;
            r_ex_shamt   <= 4'd0;
            r_ex_srl     <= 1'b0;
            r_ex_sra     <= 1'b0;
            r_ex_ls      <= 1'b0;
            r_ex_rd      <= 4'd0;
            r_ex_wr_en   <= 1'b0;
            r_ex_is_load <= 1'b0;
        end else if (w_bubble) begin
            r_ex_valid   <= 1'b0;
            r_ex_src0    <= 16'd0;
            r_ex_shamt   <= 4'd0;
            r_ex_srl     <= 1'b0;
            r_ex_sra     <= 1'b0;
            r_ex_ls      <= 1'b0;
            r_ex_rd      <= 4'd0;
            r_ex_wr_en   <= 1'b0;
            r_ex_is_load <= 1'b0;
        end else begin
            r_ex_valid   <= 1'b1;
            r_ex_src0    <= w_src0;
            r_ex_shamt   <= w_dec_shamt;
            r_ex_srl     <= w_dec_srl;
            r_ex_sra     <= w_dec_sra;
            r_ex_ls      <= w_dec_ls;
            r_ex_rd      <= w_rd;
            r_ex_wr_en   <= w_dec_wr_en;
            r_ex_is_load <= w_dec_is_load;
        end
    end

    assign bus.id_stall   = w_hazard;
    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_src0    = r_ex_src0;
    assign bus.ex_shamt   = r_ex_shamt;
    assign bus.ex_srl     = r_ex_srl;
    assign bus.ex_sra     = r_ex_sra;
    assign bus.ex_ls      = r_ex_ls;
    assign bus.ex_rd      = r_ex_rd;
    assign bus.ex_wr_en   = r_ex_wr_en;
    assign bus.ex_is_load = r_ex_is_load;

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Directed bench for id_ex_shift_stage: decode, forwarding priority, load-use stall,
// flush, r0 handling and asynchronous reset, with hand-computed expectations.
module tb_id_ex_shift_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    id_ex_shift_if bus ();

    id_ex_shift_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic valid, input logic [15:0] instr, input logic [15:0] rs_data);
        bus.id_valid   = valid;
        bus.id_instr   = instr;
        bus.id_rs_data = rs_data;
    endtask

    task automatic check_bubble(input string tag);
        check_val({tag, ".valid"}, 16'(bus.ex_valid), 16'h0);
        check_val({tag, ".ctl"},   16'({bus.ex_srl, bus.ex_sra, bus.ex_ls}), 16'h0);
        check_val({tag, ".rd"},    16'(bus.ex_rd), 16'h0);
        check_val({tag, ".src0"},  bus.ex_src0, 16'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive_id(1'b0, 16'h0000, 16'h0000);
        bus.flush      = 1'b0;
        bus.ex_result  = 16'h0000;
        bus.mem_wr_en  = 1'b0;
        bus.mem_rd     = 4'd0;
        bus.mem_result = 16'h0000;
        #12;
        check_bubble("reset");
        check_val("reset.stall", 16'(bus.id_stall), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // SRA r3,r2,#5
        drive_id(1'b1, 16'h6325, 16'h8000);
        step();
        check_val("sra.ctl",   16'({bus.ex_srl, bus.ex_sra, bus.ex_ls}), 16'h2);
        check_val("sra.shamt", 16'(bus.ex_shamt), 16'h5);
        check_val("sra.src0",  bus.ex_src0, 16'h8000);
        check_val("sra.rd",    16'(bus.ex_rd), 16'h3);
        check_val("sra.wr",    16'(bus.ex_wr_en), 16'h1);
        check_val("sra.valid", 16'(bus.ex_valid), 16'h1);

        // SLL r4,r1,#1 then SRL r5,r4,#2 forwarded from ex_result
        drive_id(1'b1, 16'h4411, 16'h0123);
        step();
        check_val("sll.src0", bus.ex_src0, 16'h0123);
        bus.ex_result = 16'h0246;
        drive_id(1'b1, 16'h5542, 16'hDEAD);
        #1;
        check_val("exfwd.stall", 16'(bus.id_stall), 16'h0);
        step();
        check_val("exfwd.src0",  bus.ex_src0, 16'h0246);
        check_val("exfwd.ctl",   16'({bus.ex_srl, bus.ex_sra, bus.ex_ls}), 16'h4);
        check_val("exfwd.rd",    16'(bus.ex_rd), 16'h5);

        // Priority: EX rd=7 beats MEM rd=7; shamt=0 still asserts ls
        drive_id(1'b1, 16'h4710, 16'h0000);
        step();
        check_val("sh0.ls",    16'(bus.ex_ls), 16'h1);
        check_val("sh0.shamt", 16'(bus.ex_shamt), 16'h0);
        bus.ex_result  = 16'h1111;
        bus.mem_wr_en  = 1'b1;
        bus.mem_rd     = 4'd7;
        bus.mem_result = 16'h2222;
        drive_id(1'b1, 16'h5271, 16'h3333);
        step();
        check_val("prio.ex", bus.ex_src0, 16'h1111);

        // Same with a non-writing EX instruction at rd=7
        drive_id(1'b1, 16'h0710, 16'h0000);
        step();
        check_val("nop.wr",    16'(bus.ex_wr_en), 16'h0);
        check_val("nop.valid", 16'(bus.ex_valid), 16'h1);
        drive_id(1'b1, 16'h5271, 16'h3333);
        step();
        check_val("prio.mem", bus.ex_src0, 16'h2222);
        bus.mem_wr_en = 1'b0;
        drive_id(1'b1, 16'h5371, 16'h3333);
        step();
        check_val("prio.rf", bus.ex_src0, 16'h3333);

        // Load-use: LW r6 then SLL r2,r6,#4
        drive_id(1'b1, 16'h8600, 16'h0000);
        step();
        check_val("lw.load",  16'(bus.ex_is_load), 16'h1);
        check_val("lw.wr",    16'(bus.ex_wr_en), 16'h1);
        check_val("lw.ctl",   16'({bus.ex_srl, bus.ex_sra, bus.ex_ls}), 16'h0);
        bus.ex_result = 16'hBEEF;
        drive_id(1'b1, 16'h4264, 16'h0000);
        #1;
        check_val("lu.stall", 16'(bus.id_stall), 16'h1);
        step();
        check_bubble("lu.bubble");
        bus.mem_wr_en  = 1'b1;
        bus.mem_rd     = 4'd6;
        bus.mem_result = 16'h00F0;
        #1;
        check_val("lu.stall2", 16'(bus.id_stall), 16'h0);
        step();
        check_val("lu.src0",  bus.ex_src0, 16'h00F0);
        check_val("lu.ls",    16'(bus.ex_ls), 16'h1);
        check_val("lu.shamt", 16'(bus.ex_shamt), 16'h4);
        bus.mem_wr_en = 1'b0;

        // Flush with a valid shift in ID
        bus.flush = 1'b1;
        drive_id(1'b1, 16'h5311, 16'h1234);
        step();
        check_bubble("flush");
        bus.flush = 1'b0;

        // SRL r0,r0,#3 with a MEM write to r0 that must be ignored
        bus.mem_wr_en  = 1'b1;
        bus.mem_rd     = 4'd0;
        bus.mem_result = 16'h7777;
        drive_id(1'b1, 16'h5003, 16'h5555);
        step();
        check_val("r0.src0",  bus.ex_src0, 16'h0000);
        check_val("r0.wr",    16'(bus.ex_wr_en), 16'h0);
        check_val("r0.srl",   16'(bus.ex_srl), 16'h1);
        check_val("r0.shamt", 16'(bus.ex_shamt), 16'h3);
        bus.mem_wr_en = 1'b0;

        // id_valid low captures a bubble
        drive_id(1'b0, 16'h4411, 16'h0123);
        step();
        check_bubble("invalid");

        // Non-shift opcode reading the load's rd does not stall; reset mid-stall
        drive_id(1'b1, 16'h8600, 16'h0000);
        step();
        drive_id(1'b1, 16'h0160, 16'h0000);
        #1;
        check_val("nors.stall", 16'(bus.id_stall), 16'h0);
        drive_id(1'b1, 16'h4264, 16'h0000);
        #1;
        check_val("rst.pre_stall", 16'(bus.id_stall), 16'h1);
        check_val("rst.pre_valid", 16'(bus.ex_valid), 16'h1);
        rst = 1'b1;
        #1;
        check_bubble("rst.mid");
        check_val("rst.load",  16'(bus.ex_is_load), 16'h0);
        check_val("rst.stall", 16'(bus.id_stall), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
